seq_divider_nr: RTL

- Sequential unsigned integer divider using the non-restoring algorithm: one add-or-subtract of the divisor per clock.
- Inverse of the datapath's add/subtract unit; it reuses that same add/sub primitive, iterated under FSM control.
- Sits beside the 4-bit arithmetic blocks. A start/done handshake runs one division at a time.

---
 rtl/div_pkg.sv | 18 +
 rtl/addsub_nbit.sv | 19 +
 rtl/seq_divider_nr.sv | 119 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring sequential divider: FSM encoding,
// default operand width and iteration-counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/addsub_nbit.sv
// Combinational N-bit adder/subtractor: sub=1 inverts b and injects a carry-in,
// giving a - b in two's complement; the carry out of the MSB is dropped.
module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);

    logic [N-1:0] b_eff;
    logic [N-1:0] cin;

    assign b_eff = b ^ {N{sub}};
    assign cin   = {{(N-1){1'b0}}, sub};
    assign sum   = a + b_eff + cin;

endmodule

// File: rtl/seq_divider_nr.sv
// Sequential unsigned non-restoring divider: one add-or-subtract of the divisor
// per clock, a final remainder correction step, and a start/done handshake.
module seq_divider_nr
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    state_t                  state;
    logic signed [WIDTH:0]   r_acc;
    logic [WIDTH-1:0]        q_reg;
    logic [WIDTH-1:0]        d_reg;
    logic [CNT_W-1:0]        count;
    logic                    zero_flag;

    logic [WIDTH:0]          r_shift;
    logic [WIDTH:0]          as_a;
    logic [WIDTH:0]          as_b;
    logic [WIDTH:0]          as_sum;
    logic                    as_sub;

    // RUN feeds the shifted partial remainder; FIX re-adds D to a negative R.
    assign r_shift = {r_acc[WIDTH-1:0], q_reg[WIDTH-1]};
    assign as_b    = {1'b0, d_reg};

    always_comb begin
        as_a   = r_acc;
        as_sub = 1'b0;
        if (state == RUN) begin
            as_a   = r_shift;
            as_sub = ~r_acc[WIDTH];
        end
    end

    addsub_nbit #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .sum (as_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            r_acc       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            zero_flag   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_reg     <= divisor;
                        q_reg     <= dividend;
                        r_acc     <= '0;
                        count     <= '0;
                        zero_flag <= (divisor == '0);
                        ready     <= 1'b0;
                        state     <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    r_acc <= $signed(as_sum);
                    q_reg <= {q_reg[WIDTH-2:0], ~as_sum[WIDTH]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b1;
                    if (r_acc[WIDTH]) begin
                        r_acc <= $signed(as_sum);
                    end
                    // Zero divisor skips RUN, so q_reg still holds the dividend.
                    if (zero_flag) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_reg;
                        remainder   <= r_acc[WIDTH] ? as_sum[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
